// File: rtl/assoc_cache_system_pkg.sv
// Shared types and address-field helpers for the set-associative write-through cache.
package assoc_cache_system_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_e;

  function automatic int off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Bit 0 is the byte select; everything above offset and index is tag.
  function automatic int tag_w(input int awidth, input int block_words, input int sets);
    return awidth - 1 - off_w(block_words) - idx_w(sets);
  endfunction

  localparam int OFF_W = off_w(8);
  localparam int IDX_W = idx_w(8);
  localparam int TAG_W = tag_w(16, 8, 8);

  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int ow);
    return (addr >> 1) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ow, input int iw);
    return (addr >> (1 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ow, input int iw);
    return addr >> (1 + ow + iw);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: tag, valid and data storage with a combinational lookup port
// and a single write port (data word write plus tag/valid install).
module cache_way_array
  import assoc_cache_system_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int TAG_BITS = TAG_W,
  parameter int IDX_BITS = IDX_W,
  parameter int OFF_BITS = OFF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] lk_idx,
  input  logic [OFF_BITS-1:0] lk_off,
  input  logic [TAG_BITS-1:0] lk_tag,
  output logic                hit,
  output logic                vld,
  output logic [DWIDTH-1:0]   rdata,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic                tag_wr,
  input  logic [TAG_BITS-1:0] tag_val
);

  localparam int NSETS  = 1 << IDX_BITS;
  localparam int NWORDS = NSETS << OFF_BITS;

  logic [DWIDTH-1:0]   data_mem [NWORDS];
  logic [TAG_BITS-1:0] tag_mem  [NSETS];
  logic [NSETS-1:0]    valid_q;

  // Data and tags are left unreset; only the valid bits gate a hit.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[{wr_idx, wr_off}] <= wr_data;
    if (tag_wr) tag_mem[wr_idx] <= tag_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        valid_q <= '0;
    else if (tag_wr) valid_q[wr_idx] <= 1'b1;
  end

  assign vld   = valid_q[lk_idx];
  assign hit   = vld && (tag_mem[lk_idx] == lk_tag);
  assign rdata = data_mem[{lk_idx, lk_off}];

endmodule

// File: rtl/assoc_cache_system.sv
// Set-associative write-through, no-write-allocate cache with a block-fill FSM.
// Memory port: a request transfers on any cycle where mem_req_valid && mem_req_ready; responses arrive in order.
module assoc_cache_system
  import assoc_cache_system_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 16,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              cache_miss_stall,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DWIDTH-1:0] mem_rsp_data
);

  localparam int OFF_BITS = off_w(BLOCK_WORDS);
  localparam int IDX_BITS = idx_w(SETS);
  localparam int TAG_BITS = tag_w(AWIDTH, BLOCK_WORDS, SETS);

  logic [OFF_BITS-1:0] acc_off;
  logic [IDX_BITS-1:0] acc_idx;
  logic [TAG_BITS-1:0] acc_tag;

  assign acc_off = OFF_BITS'(addr_offset(32'(addr_in), OFF_BITS));
  assign acc_idx = IDX_BITS'(addr_index(32'(addr_in), OFF_BITS, IDX_BITS));
  assign acc_tag = TAG_BITS'(addr_tag(32'(addr_in), OFF_BITS, IDX_BITS));

  cache_state_e        state_q, state_d;
  logic [OFF_BITS:0]   req_cnt_q;
  logic [OFF_BITS-1:0] rsp_cnt_q;
  logic                victim_q, victim_sel;
  logic [IDX_BITS-1:0] fill_idx_q;
  logic [TAG_BITS-1:0] fill_tag_q;
  logic                start_fill;

  logic [WAYS-1:0]     way_hit, way_vld, way_wr_en, way_tag_wr;
  logic [DWIDTH-1:0]   way_rdata [WAYS];
  logic [IDX_BITS-1:0] wr_idx;
  logic [OFF_BITS-1:0] wr_off;
  logic [DWIDTH-1:0]   wr_data;
  logic                hit_any, hit_way;

  logic                lru_cur, lru_upd, lru_val;
  logic [IDX_BITS-1:0] lru_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .DWIDTH   (DWIDTH),
      .TAG_BITS (TAG_BITS),
      .IDX_BITS (IDX_BITS),
      .OFF_BITS (OFF_BITS)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .lk_idx  (acc_idx),
      .lk_off  (acc_off),
      .lk_tag  (acc_tag),
      .hit     (way_hit[w]),
      .vld     (way_vld[w]),
      .rdata   (way_rdata[w]),
      .wr_en   (way_wr_en[w]),
      .wr_idx  (wr_idx),
      .wr_off  (wr_off),
      .wr_data (wr_data),
      .tag_wr  (way_tag_wr[w]),
      .tag_val (fill_tag_q)
    );
  end

  // Per-set bit naming the least recently used way; absent when direct-mapped.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         lru_q <= '0;
      else if (lru_upd) lru_q[lru_idx] <= lru_val;
    end
    assign lru_cur = lru_q[acc_idx];
  end else begin : g_no_lru
    assign lru_cur = 1'b0;
  end

  always_comb begin
    hit_way = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (way_hit[i]) hit_way = 1'(i);
    end
  end

  assign hit_any    = |way_hit;
  assign victim_sel = !way_vld[0] ? 1'b0 :
                      ((WAYS == 2) && !way_vld[WAYS-1]) ? 1'b1 : lru_cur;

  always_comb begin
    state_d          = state_q;
    data_out         = '0;
    cache_miss_stall = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    way_wr_en        = '0;
    way_tag_wr       = '0;
    wr_idx           = acc_idx;
    wr_off           = acc_off;
    wr_data          = data_in;
    lru_upd          = 1'b0;
    lru_idx          = acc_idx;
    lru_val          = ~hit_way;
    start_fill       = 1'b0;
    // Outputs are forced low for as long as reset is held.
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (mem_en && mem_write) begin
            mem_req_valid    = 1'b1;
            mem_req_write    = 1'b1;
            mem_req_addr     = {addr_in[AWIDTH-1:1], 1'b0};
            mem_req_wdata    = data_in;
            cache_miss_stall = !mem_req_ready;
            if (mem_req_ready && hit_any) begin
              way_wr_en[hit_way] = 1'b1;
              lru_upd            = 1'b1;
            end
          end else if (mem_en && mem_read) begin
            if (hit_any) begin
              data_out = way_rdata[hit_way];
              lru_upd  = 1'b1;
            end else begin
              cache_miss_stall = 1'b1;
              start_fill       = 1'b1;
              state_d          = FILL;
            end
          end
        end
        FILL: begin
          cache_miss_stall = 1'b1;
          mem_req_valid    = !req_cnt_q[OFF_BITS];
          mem_req_addr     = {fill_tag_q, fill_idx_q, req_cnt_q[OFF_BITS-1:0], 1'b0};
          wr_idx           = fill_idx_q;
          wr_off           = rsp_cnt_q;
          wr_data          = mem_rsp_data;
          if (mem_rsp_valid) begin
            way_wr_en[victim_q] = 1'b1;
            if (&rsp_cnt_q) begin
              way_tag_wr[victim_q] = 1'b1;
              lru_upd              = 1'b1;
              lru_idx              = fill_idx_q;
              lru_val              = ~victim_q;
              state_d              = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The fill target is latched so the block completes even if the requester lets go.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      victim_q   <= 1'b0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_fill) begin
        req_cnt_q  <= '0;
        rsp_cnt_q  <= '0;
        victim_q   <= victim_sel;
        fill_idx_q <= acc_idx;
        fill_tag_q <= acc_tag;
      end else if (state_q == FILL) begin
        if (mem_req_valid && mem_req_ready) req_cnt_q <= req_cnt_q + 1'b1;
        if (mem_rsp_valid)                  rsp_cnt_q <= rsp_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache_system.sv
// Bench for assoc_cache_system: directed cases plus randomized accesses against an LRU residency model.
module tb_assoc_cache_system;

  localparam int BW   = 8;
  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_read, mem_write;
  logic [15:0] addr_in, data_in;
  logic [15:0] data_out;
  logic        cache_miss_stall;
  logic        mem_req_valid, mem_req_write;
  logic [15:0] mem_req_addr, mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data  = '0;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_seen = 0;
  int wr_seen  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem_img [32768];
  int          res_tag [SETS][WAYS];
  int          res_n   [SETS];

  assoc_cache_system dut (
    .clk              (clk),
    .rst              (rst),
    .mem_en           (mem_en),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .addr_in          (addr_in),
    .data_in          (data_in),
    .data_out         (data_out),
    .cache_miss_stall (cache_miss_stall),
    .mem_req_valid    (mem_req_valid),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- main memory: 2-cycle read latency, in-order responses ----
  logic        smp_fire = 1'b0, smp_write = 1'b0;
  logic [15:0] smp_addr = '0, smp_wdata = '0;
  logic        s1_v = 1'b0;
  logic [15:0] s1_d = '0;

  always @(negedge clk) begin
    smp_fire  = mem_req_valid && mem_req_ready;
    smp_write = mem_req_write;
    smp_addr  = mem_req_addr;
    smp_wdata = mem_req_wdata;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v          <= 1'b0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      if (mem_rsp_valid) rsp_seen++;
      mem_rsp_valid <= s1_v;
      mem_rsp_data  <= s1_d;
      s1_v          <= 1'b0;
      if (smp_fire) begin
        if (smp_write) begin
          mem_img[smp_addr[15:1]] = smp_wdata;
          wr_seen++;
        end else begin
          if (exp_q.size() == 0) chk("rd_unexpected", {16'h0, smp_addr}, 32'hFFFF_FFFF);
          else                   chk("fill_addr", {16'h0, smp_addr}, {16'h0, exp_q.pop_front()});
          s1_v <= 1'b1;
          s1_d <= mem_img[smp_addr[15:1]];
        end
      end
    end
  end

  // ---- reference model: per-set residency list, most recently used first ----
  function automatic void ref_clear();
    for (int s = 0; s < SETS; s++) res_n[s] = 0;
  endfunction

  function automatic int ref_find(input int idx, input int tag);
    for (int i = 0; i < res_n[idx]; i++) if (res_tag[idx][i] == tag) return i;
    return -1;
  endfunction

  function automatic void ref_touch(input int idx, input int tag);
    int p;
    p = ref_find(idx, tag);
    if (p < 0) begin
      if (res_n[idx] < WAYS) res_n[idx]++;
      p = res_n[idx] - 1;
    end
    for (int i = p; i > 0; i--) res_tag[idx][i] = res_tag[idx][i-1];
    res_tag[idx][0] = tag;
  endfunction

  task automatic ref_predict(input bit wr, input logic [15:0] a, output bit hit);
    int idx, tag, blk;
    blk = int'(a) / (2 * BW);
    idx = blk % SETS;
    tag = blk / SETS;
    hit = (ref_find(idx, tag) >= 0);
    if (!wr || hit) ref_touch(idx, tag);
    if (!wr && !hit)
      for (int i = 0; i < BW; i++) exp_q.push_back(16'(blk * 2 * BW + 2 * i));
  endtask

  // ---- driver tasks ----
  task automatic idle_inputs();
    mem_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_req_ready = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data_out"}, {16'h0, data_out}, 32'h0);
    chk({tag, "_stall"},    {31'h0, cache_miss_stall}, 32'h0);
    chk({tag, "_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
    chk({tag, "_req_write"}, {31'h0, mem_req_write}, 32'h0);
    chk({tag, "_req_addr"},  {16'h0, mem_req_addr}, 32'h0);
    chk({tag, "_req_wdata"}, {16'h0, mem_req_wdata}, 32'h0);
  endtask

  task automatic do_access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input int low_cycles, input bit rnd_ready);
    bit          exp_hit, done;
    logic [15:0] exp_data;
    int          cyc, stall_cnt, wr_base;
    exp_data = wr ? d : mem_img[a[15:1]];
    ref_predict(wr, a, exp_hit);
    wr_base = wr_seen;
    @(posedge clk); #1;
    mem_en    = 1'b1;
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    addr_in   = a;
    data_in   = d;
    cyc = 0; stall_cnt = 0; done = 1'b0;
    while (!done && cyc < 300) begin
      if (wr) mem_req_ready = (cyc >= low_cycles);
      else    mem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (wr) begin
        if (cyc == 0) begin
          chk("wr_req_valid", {31'h0, mem_req_valid}, 32'h1);
          chk("wr_req_write", {31'h0, mem_req_write}, 32'h1);
          chk("wr_req_addr",  {16'h0, mem_req_addr}, {16'h0, a[15:1], 1'b0});
          chk("wr_req_wdata", {16'h0, mem_req_wdata}, {16'h0, d});
        end
        chk("wr_stall", {31'h0, cache_miss_stall}, {31'h0, !mem_req_ready});
      end else if (cyc == 0) begin
        chk("rd_stall", {31'h0, cache_miss_stall}, {31'h0, !exp_hit});
      end
      if (!cache_miss_stall) begin
        done = 1'b1;
        if (!wr) begin
          chk("rd_data",   {16'h0, data_out}, {16'h0, exp_data});
          chk("rd_no_req", {31'h0, mem_req_valid}, 32'h0);
        end
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("acc_done", {31'h0, done}, 32'h1);
    idle_inputs();
    if (wr)              chk("wr_stall_cycles", stall_cnt, low_cycles);
    else if (!rnd_ready) chk("rd_stall_cycles", stall_cnt, exp_hit ? 0 : 1 + BW + LAT);
    chk("fill_reqs_left", exp_q.size(), 0);
    chk("wr_req_count", wr_seen - wr_base, wr ? 1 : 0);
  endtask

  // Miss whose requester walks away mid-fill; the block must still land.
  task automatic fill_then_drop(input logic [15:0] a);
    bit hit;
    ref_predict(1'b0, a, hit);
    @(posedge clk); #1;
    mem_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr_in = a; mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_en = 1'b0; mem_read = 1'b0; addr_in = 16'($urandom);
    repeat (BW + 6) @(posedge clk);
    @(negedge clk);
    chk("drop_stall", {31'h0, cache_miss_stall}, 32'h0);
    chk("drop_fill_reqs", exp_q.size(), 0);
  endtask

  task automatic reset_mid_fill(input logic [15:0] a);
    bit hit;
    int base, n;
    ref_predict(1'b0, a, hit);
    @(posedge clk); #1;
    mem_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr_in = a; mem_req_ready = 1'b1;
    base = rsp_seen; n = 0;
    while ((rsp_seen - base) < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("rmf_rsp_wait", {31'h0, (rsp_seen - base) >= 3}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk_outputs_zero("rmf_async");
    exp_q.delete();
    ref_clear();
    @(negedge clk);
    chk_outputs_zero("rmf_hold");
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
  endtask

  // ---- stimulus ----
  initial begin
    logic [15:0] ra;
    bit          rw;
    for (int i = 0; i < 32768; i++) mem_img[i] = 16'(2 * i) ^ 16'h5A5A;
    ref_clear();
    rst = 1'b0;
    mem_en = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    addr_in = 16'h1234; data_in = 16'hBEEF; mem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    idle_inputs();
    rst = 1'b1;

    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0012, 16'h0000, 0, 1'b0);
    do_access(1'b1, 16'hFFFF, 16'hABCD, 3, 1'b0);
    do_access(1'b0, 16'hFFFE, 16'h0000, 0, 1'b0);

    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0090, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0110, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0090, 16'h0000, 0, 1'b0);

    do_access(1'b1, 16'h0014, 16'h1234, 0, 1'b0);
    do_access(1'b0, 16'h0014, 16'h0000, 0, 1'b0);

    fill_then_drop(16'h0210);
    do_access(1'b0, 16'h0210, 16'h0000, 0, 1'b0);

    do_access(1'b0, 16'h0090, 16'h0000, 0, 1'b0);
    do_access(1'b0, 16'h0110, 16'h0000, 0, 1'b0);
    reset_mid_fill(16'h0010);
    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom_range(0, 3) * 128 + $urandom_range(0, 7) * 16 +
               $urandom_range(0, 7) * 2 + $urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ra = 16'($urandom);
      rw = ($urandom_range(0, 9) < 3);
      do_access(rw, ra, 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 1)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
